// File: rtl/controlador_entrada_saida_if.sv
// ============================================================================
// controlador_entrada_saida_if
// Bus between the datapath and the switch/display I/O controller.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface controlador_entrada_saida_if;
   logic [4:0]  opcode;
   logic        enter;
   logic [8:0]  entradaSwitch;
   logic [31:0] dadoSaida;
   logic        pcHabilita;
   logic        regEscrita;
   logic [31:0] dadoEntrada;
   logic [31:0] saidaValor;
   logic        saidaValida;
   logic [1:0]  estado;

   modport master (
      output opcode, enter, entradaSwitch, dadoSaida,
      input  pcHabilita, regEscrita, dadoEntrada, saidaValor, saidaValida, estado
   );

   modport slave (
      input  opcode, enter, entradaSwitch, dadoSaida,
      output pcHabilita, regEscrita, dadoEntrada, saidaValor, saidaValida, estado
   );
endinterface

`default_nettype wire

// File: rtl/controlador_entrada_saida.sv
// ============================================================================
// controlador_entrada_saida
// Stalls the PC for debounced switch input (IN) and latches display values (OUT).
// Revision: 1.0
// ============================================================================
`default_nettype none

module controlador_entrada_saida #(
   parameter logic [4:0]  OPCODE_IN  = 5'd30,
   parameter logic [4:0]  OPCODE_OUT = 5'd31,
   parameter logic [15:0] DEBOUNCE   = 16'd50000
) (
   input  wire logic                   clock,
   input  wire logic                   reset,
   controlador_entrada_saida_if.slave  bus
);

   localparam logic [1:0]  c_OCIOSO  = 2'd0;
   localparam logic [1:0]  c_ARMA    = 2'd1;
   localparam logic [1:0]  c_ESPERA  = 2'd2;
   localparam logic [1:0]  c_ESCREVE = 2'd3;
   localparam logic [15:0] c_ULTIMO  = DEBOUNCE - 16'd1;

   logic [1:0]  estado_q, estado_d;
   logic [15:0] cont_q, cont_d;
   logic        enter_meta_q, enter_sinc_q;
   logic [31:0] dadoEntrada_q;
   logic [31:0] saidaValor_q;
   logic        saidaValida_q;
   logic        captura_w;
   logic        saida_w;
   logic        pcHabilita_w;
   logic        regEscrita_w;

   assign captura_w = (estado_q == c_ESPERA) && !enter_sinc_q && (cont_q == c_ULTIMO);
   assign saida_w   = (estado_q == c_OCIOSO) && (bus.opcode == OPCODE_OUT);

   // State register, synchronizer and datapath registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estado_q      <= c_OCIOSO;
         cont_q        <= 16'd0;
         enter_meta_q  <= 1'b1;
         enter_sinc_q  <= 1'b1;
         dadoEntrada_q <= 32'd0;
         saidaValor_q  <= 32'd0;
         saidaValida_q <= 1'b0;
      end else begin
         estado_q      <= estado_d;
         cont_q        <= cont_d;
         enter_meta_q  <= bus.enter;
         enter_sinc_q  <= enter_meta_q;
         if (captura_w) begin
            dadoEntrada_q <= {{23{bus.entradaSwitch[8]}}, bus.entradaSwitch};
         end
         if (saida_w) begin
            saidaValor_q  <= bus.dadoSaida;
            saidaValida_q <= 1'b1;
         end
      end
   end

   // Next state; the counter only runs in ESPERA and any released sample clears it
   always_comb begin
      estado_d = estado_q;
      cont_d   = 16'd0;
      case (estado_q)
         c_OCIOSO: begin
            if (bus.opcode == OPCODE_IN) estado_d = c_ARMA;
         end
         c_ARMA: begin
            if (enter_sinc_q) estado_d = c_ESPERA;
         end
         c_ESPERA: begin
            if (enter_sinc_q) begin
               cont_d = 16'd0;
            end else if (cont_q == c_ULTIMO) begin
               cont_d   = 16'd0;
               estado_d = c_ESCREVE;
            end else begin
               cont_d = cont_q + 16'd1;
            end
         end
         default: begin
            estado_d = c_OCIOSO;
         end
      endcase
   end

   always_comb begin
      pcHabilita_w = 1'b0;
      regEscrita_w = 1'b0;
      case (estado_q)
         c_OCIOSO:  pcHabilita_w = (bus.opcode != OPCODE_IN);
         c_ESCREVE: begin
            pcHabilita_w = 1'b1;
            regEscrita_w = 1'b1;
         end
         default: begin
            pcHabilita_w = 1'b0;
            regEscrita_w = 1'b0;
         end
      endcase
   end

   assign bus.pcHabilita  = pcHabilita_w;
   assign bus.regEscrita  = regEscrita_w;
   assign bus.dadoEntrada = dadoEntrada_q;
   assign bus.saidaValor  = saidaValor_q;
   assign bus.saidaValida = saidaValida_q;
   assign bus.estado      = estado_q;

endmodule

`default_nettype wire

// File: tb/tb_controlador_entrada_saida.sv
// ============================================================================
// tb_controlador_entrada_saida
// Directed bench with a write scoreboard, DEBOUNCE=4.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_controlador_entrada_saida;

   logic clock = 1'b0;
   logic reset = 1'b0;
   controlador_entrada_saida_if u ();

   controlador_entrada_saida #(
      .OPCODE_IN (5'd30),
      .OPCODE_OUT(5'd31),
      .DEBOUNCE  (16'd4)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (u.slave)
   );

   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_err = 0;
   logic [31:0] exp_q[$];

   task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
      n_cmp++;
      if (atual !== esperado) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nome, atual, esperado);
      end
   endtask

   // Monitor: every write strobe must match the oldest expected write
   always @(negedge clock) begin
      if (reset && u.regEscrita === 1'b1) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_write: got dadoEntrada %0h expected no write", u.dadoEntrada);
         end else begin
            automatic logic [31:0] e = exp_q.pop_front();
            if (u.dadoEntrada !== e) begin
               n_err++;
               $display("FAIL write_data: got %0h expected %0h", u.dadoEntrada, e);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic wait_state(input logic [1:0] alvo, input string nome);
      int n = 0;
      while (u.estado !== alvo && n < 20) begin
         tick();
         n++;
      end
      check(nome, {30'd0, u.estado}, {30'd0, alvo});
   endtask

   // Ticks until ESCREVE; returns edges taken and whether PC stalled throughout
   task automatic wait_write(input string nome);
      int  n = 0;
      bit  parou = 1'b1;
      while (u.estado !== 2'd3 && n < 40) begin
         if (u.pcHabilita !== 1'b0) parou = 1'b0;
         tick();
         n++;
      end
      check({nome, "_latency"}, n, 32'd6);
      check({nome, "_stall"}, {31'd0, parou}, 32'd1);
      check({nome, "_pc_escreve"}, {31'd0, u.pcHabilita}, 32'd1);
   endtask

   initial begin
      u.opcode        = 5'd0;
      u.enter         = 1'b1;
      u.entradaSwitch = 9'd0;
      u.dadoSaida     = 32'd0;
      #2;
      check("rst_estado",      {30'd0, u.estado},      32'd0);
      check("rst_regEscrita",  {31'd0, u.regEscrita},  32'd0);
      check("rst_dadoEntrada", u.dadoEntrada,          32'd0);
      check("rst_saidaValor",  u.saidaValor,           32'd0);
      check("rst_saidaValida", {31'd0, u.saidaValida}, 32'd0);
      check("rst_pcHabilita",  {31'd0, u.pcHabilita},  32'd1);
      tick();
      reset = 1'b1;
      repeat (3) tick();

      // Negative switch value, clean press
      u.opcode        = 5'd30;
      u.entradaSwitch = 9'h1FF;
      #1;
      check("in_pc_comb", {31'd0, u.pcHabilita}, 32'd0);
      tick();
      check("in_arma", {30'd0, u.estado}, 32'd1);
      wait_state(2'd2, "t1_espera");
      exp_q.push_back(32'hFFFF_FFFF);
      u.enter = 1'b0;
      wait_write("t1");
      u.opcode = 5'd0;
      tick();
      check("t1_ocioso", {30'd0, u.estado}, 32'd0);
      check("t1_pc_ocioso", {31'd0, u.pcHabilita}, 32'd1);
      u.enter = 1'b1;
      repeat (3) tick();

      // Glitch restarts the debounce count
      u.opcode        = 5'd30;
      u.entradaSwitch = 9'd5;
      wait_state(2'd2, "t2_espera");
      u.enter = 1'b0;
      repeat (3) tick();
      u.enter = 1'b1;
      tick();
      u.enter = 1'b0;
      exp_q.push_back(32'd5);
      wait_write("t2");
      u.opcode = 5'd0;
      u.enter  = 1'b1;
      repeat (3) tick();

      // Press held over from before the instruction must not be reused
      u.enter         = 1'b0;
      repeat (3) tick();
      u.opcode        = 5'd30;
      u.entradaSwitch = 9'd123;
      repeat (2) tick();
      u.opcode    = 5'd31;
      u.dadoSaida = 32'd999;
      repeat (6) tick();
      check("t3_held_arma",  {30'd0, u.estado},      32'd1);
      check("t3_out_ignored", u.saidaValor,          32'd0);
      check("t3_valida_0",   {31'd0, u.saidaValida}, 32'd0);
      u.opcode = 5'd0;
      u.enter  = 1'b1;
      wait_state(2'd2, "t3_espera");
      exp_q.push_back(32'd123);
      u.enter = 1'b0;
      wait_write("t3");
      u.enter = 1'b1;
      tick();
      u.entradaSwitch = 9'd0;
      repeat (3) tick();
      check("t3_hold_dado", u.dadoEntrada, 32'd123);

      // OUT instruction
      u.opcode    = 5'd31;
      u.dadoSaida = 32'd456;
      #1;
      check("out_pc", {31'd0, u.pcHabilita}, 32'd1);
      tick();
      check("out_valor",  u.saidaValor,           32'd456);
      check("out_valida", {31'd0, u.saidaValida}, 32'd1);
      u.opcode    = 5'd0;
      u.dadoSaida = 32'd789;
      repeat (2) tick();
      check("out_hold", u.saidaValor, 32'd456);

      // Asynchronous reset during ESPERA
      u.opcode = 5'd30;
      wait_state(2'd2, "t5_espera");
      u.enter = 1'b0;
      repeat (2) tick();
      #2;
      reset = 1'b0;
      #1;
      check("ar_estado",  {30'd0, u.estado},      32'd0);
      check("ar_regEsc",  {31'd0, u.regEscrita},  32'd0);
      check("ar_valor",   u.saidaValor,           32'd0);
      check("ar_valida",  {31'd0, u.saidaValida}, 32'd0);
      check("ar_dado",    u.dadoEntrada,          32'd0);
      u.opcode = 5'd0;
      repeat (2) tick();
      reset = 1'b1;
      repeat (8) tick();
      check("ar_pc_after", {31'd0, u.pcHabilita}, 32'd1);
      u.enter = 1'b1;
      repeat (3) tick();

      // Back-to-back IN with the button held down throughout
      u.opcode        = 5'd30;
      u.entradaSwitch = 9'h100;
      wait_state(2'd2, "t6_espera");
      exp_q.push_back(32'hFFFF_FF00);
      u.enter = 1'b0;
      wait_write("t6a");
      u.entradaSwitch = 9'd7;
      repeat (10) tick();
      check("t6_wait_arma", {30'd0, u.estado}, 32'd1);
      u.enter = 1'b1;
      wait_state(2'd2, "t6_espera2");
      exp_q.push_back(32'd7);
      u.enter = 1'b0;
      wait_write("t6b");
      u.opcode = 5'd0;
      u.enter  = 1'b1;
      repeat (4) tick();

      check("scoreboard_empty", exp_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/controlador_entrada_saida.md
CONTROLADOR_ENTRADA_SAIDA -- requirements
Module: controlador_entrada_saida

Interface
- REQ-001: Parameter OPCODE_IN, default 5'd30: opcode of the switch-input instruction.
- REQ-002: Parameter OPCODE_OUT, default 5'd31: opcode of the display-output instruction.
- REQ-003: Parameter DEBOUNCE, default 16'd50000: consecutive low samples of enter required to accept a press; legal range 1..65535.
- REQ-004: clock  input  1  system clock (divided clock from temporizador); all state changes on rising edge.
- REQ-005: reset  input  1  asynchronous, active-low reset.
- REQ-006: opcode  input  5  opcode of the instruction currently addressed by PC.
- REQ-007: enter  input  1  raw push button, active-low (0 = pressed), asynchronous to clock.
- REQ-008: entradaSwitch  input  9  two's-complement value on switches.
- REQ-009: dadoSaida  input  32  register value to be displayed (register read port rd).
- REQ-010: pcHabilita  output  1  1 = PC may advance this cycle; 0 = stall.
- REQ-011: regEscrita  output  1  one-cycle write strobe to register bank for input instruction.
- REQ-012: dadoEntrada  output  32  captured, sign-extended switch value.
- REQ-013: saidaValor  output  32  value held for the display decoder.
- REQ-014: saidaValida  output  1  1 once any OUT instruction has executed since reset.
- REQ-015: estado  output  2  current FSM state code, for debug display.

Function
- REQ-016: FSM states SHALL be OCIOSO=2'd0, ARMA=2'd1, ESPERA=2'd2, ESCREVE=2'd3.
- REQ-017: enter SHALL pass through a two-flop synchronizer before any use; all "enter" below means the synchronized value (2-cycle latency).
- REQ-018: OCIOSO: if opcode==OPCODE_IN, pcHabilita=0 combinationally in that same cycle and next state ARMA; otherwise pcHabilita=1 and state stays OCIOSO.
- REQ-019: ARMA: pcHabilita=0; next state ESPERA when enter==1 (button released), else remain, so a press held over from a prior input is never reused.
- REQ-020: ESPERA: pcHabilita=0; 16-bit counter increments each cycle enter==0 and clears to 0 on any cycle enter==1.
- REQ-021: When enter==0 and counter==DEBOUNCE-1 in ESPERA, next state ESCREVE, counter clears, and dadoEntrada loads {{23{entradaSwitch[8]}}, entradaSwitch} on that same edge.
- REQ-022: ESCREVE: regEscrita=1 and pcHabilita=1 for exactly one cycle; next state OCIOSO unconditionally.
- REQ-023: regEscrita SHALL be 0 in every state other than ESCREVE.
- REQ-024: entradaSwitch changes outside the capture edge SHALL NOT affect dadoEntrada.
- REQ-025: OUT: in OCIOSO with opcode==OPCODE_OUT, saidaValor loads dadoSaida and saidaValida sets to 1 on the next edge; no stall (pcHabilita=1).
- REQ-026: OUT opcode while state is not OCIOSO SHALL be ignored; saidaValor holds.
- REQ-027: Back-to-back IN instructions SHALL each require a fresh release-then-press; ESCREVE -> OCIOSO -> ARMA sequencing enforces it.
- REQ-028: Counter SHALL never exceed DEBOUNCE-1 nor wrap.
- REQ-029: With DEBOUNCE=1, a single synchronized low sample in ESPERA SHALL suffice.

Reset
- REQ-030: reset==0 SHALL immediately force state OCIOSO, counter 0, synchronizer flops 1, dadoEntrada 0, saidaValor 0, saidaValida 0, regEscrita 0.
- REQ-031: Reset mid-input (ARMA/ESPERA/ESCREVE) SHALL abort with no regEscrita pulse; pcHabilita follows REQ-018 after release.
- REQ-032: Release of reset SHALL take effect on the first rising clock edge with reset==1.

Verification (DEBOUNCE=4)
- REQ-033: opcode=30, enter held 1, switches=9'h1FF, then enter low 4+2 cycles -> pcHabilita 0 until ESCREVE; one regEscrita pulse; dadoEntrada=32'hFFFFFFFF.
- REQ-034: In ESPERA, enter low 3 cycles, high 1, low 4 -> no write after first burst; write after second; counter cleared by glitch.
- REQ-035: opcode=30 entered with enter already held low -> stays ARMA, no write until release then 4-cycle press; switches=9'd123 -> dadoEntrada=123.
- REQ-036: opcode=31, dadoSaida=32'd456 in OCIOSO -> next edge saidaValor=456, saidaValida=1, pcHabilita stays 1.
- REQ-037: reset=0 asserted during ESPERA -> state=0, regEscrita never pulses, saidaValor=0, saidaValida=0 immediately without clock.
- REQ-038: Two consecutive IN instructions with continuous press -> exactly one write, second waits in ARMA until release.
